trap_peak_ctrl: RTL and testbench

TRAP_PEAK_CTRL -- requirements
Module: trap_peak_ctrl

---
 rtl/trap_peak_ctrl.sv | 160 ++++++++++++++++
 tb/tb_trap_peak_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_peak_ctrl.sv
// ============================================================================
// Module      : trap_peak_ctrl
// Description : Trapezoid-filter peak capture. The block triggers on a threshold
//               crossing and qualifies the rise. It records the flat-top maximum
//               and hands off the event record, then enforces a pile-up aware
//               holdoff.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_peak_ctrl #(
   parameter int SIZE_OUT_DATA = 16,
   parameter int K             = 4,
   parameter int L             = 8,
   parameter int TS_W          = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     sample_valid,
   input  logic [SIZE_OUT_DATA-1:0] filt_data,
   input  logic [SIZE_OUT_DATA-1:0] threshold,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [SIZE_OUT_DATA-1:0] evt_amp,
   output logic [TS_W-1:0]          evt_ts,
   output logic                     busy,
   output logic [7:0]               reject_cnt,
   output logic [7:0]               pileup_cnt
);

   localparam int HOLD_LEN = K + L;
   // One spare count of headroom so the increment never wraps back to zero.
   localparam int CNT_W    = $clog2(HOLD_LEN + 2);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_K    = CNT_W'(K);
   localparam logic [CNT_W-1:0] C_L    = CNT_W'(L);
   localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_LEN);
   localparam logic [TS_W-1:0]  C_TS_ONE = TS_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_RISE    = 3'd2,
      S_FLAT    = 3'd3,
      S_REPORT  = 3'd4,
      S_HOLDOFF = 3'd5
   } state_t;

   state_t                   state_q, state_d;
   logic [TS_W-1:0]          ts_q, ts_d;
   logic [TS_W-1:0]          evt_ts_q, evt_ts_d;
   logic [SIZE_OUT_DATA-1:0] max_q, max_d;
   logic [CNT_W-1:0]         idx_q, idx_d;
   logic                     below_q, below_d;
   logic [7:0]               rej_q, rej_d;
   logic [7:0]               pile_q, pile_d;

   logic                     above;
   logic [CNT_W-1:0]         idx_inc;

   assign above   = filt_data > threshold;
   assign idx_inc = idx_q + C_ONE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         ts_q     <= '0;
         evt_ts_q <= '0;
         max_q    <= '0;
         idx_q    <= '0;
         below_q  <= 1'b0;
         rej_q    <= '0;
         pile_q   <= '0;
      end else begin
         state_q  <= state_d;
         ts_q     <= ts_d;
         evt_ts_q <= evt_ts_d;
         max_q    <= max_d;
         idx_q    <= idx_d;
         below_q  <= below_d;
         rej_q    <= rej_d;
         pile_q   <= pile_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ts_d     = sample_valid ? (ts_q + C_TS_ONE) : ts_q;
      evt_ts_d = evt_ts_q;
      max_d    = max_q;
      idx_d    = idx_q;
      below_d  = below_q;
      rej_d    = rej_q;
      pile_d   = pile_q;

      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_ARMED;
            S_ARMED: begin
               if (sample_valid && above) begin
                  evt_ts_d = ts_q;
                  idx_d    = '0;
                  state_d  = S_RISE;
               end
            end
            S_RISE: begin
               if (sample_valid) begin
                  if (!above) begin
                     rej_d   = (rej_q != 8'hFF) ? (rej_q + 8'd1) : rej_q;
                     state_d = S_ARMED;
                  end else begin
                     idx_d = idx_inc;
                     if (idx_inc == C_K) state_d = S_FLAT;
                  end
               end
            end
            S_FLAT: begin
               if (sample_valid) begin
                  idx_d = idx_inc;
                  // The first flat-top sample seeds the maximum.
                  if ((idx_q == C_K) || (filt_data > max_q)) max_d = filt_data;
                  if (idx_inc == C_L) state_d = S_REPORT;
               end
            end
            S_REPORT: begin
               if (evt_ready) begin
                  idx_d   = '0;
                  below_d = 1'b0;
                  state_d = S_HOLDOFF;
               end
            end
            S_HOLDOFF: begin
               if (sample_valid) begin
                  // A crossing needs a sub-threshold sample seen inside this holdoff.
                  if (above && below_q)
                     pile_d = (pile_q != 8'hFF) ? (pile_q + 8'd1) : pile_q;
                  below_d = !above;
                  if (idx_q != C_HOLD) idx_d = idx_inc;
                  if ((idx_inc >= C_HOLD) && !above) state_d = S_ARMED;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign evt_valid  = (state_q == S_REPORT);
   assign busy       = (state_q == S_RISE) || (state_q == S_FLAT) ||
                       (state_q == S_REPORT) || (state_q == S_HOLDOFF);
   assign evt_amp    = max_q;
   assign evt_ts     = evt_ts_q;
   assign reject_cnt = rej_q;
   assign pileup_cnt = pile_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_peak_ctrl.sv
// ============================================================================
// Module      : tb_trap_peak_ctrl
// Description : Directed and randomized checks of trap_peak_ctrl against an
//               event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_peak_ctrl;

   localparam int DW = 16;
   localparam int K  = 4;
   localparam int L  = 8;
   localparam int TW = 8;

   localparam int P_IDLE   = 0;
   localparam int P_ARMED  = 1;
   localparam int P_PULSE  = 2;
   localparam int P_REPORT = 3;
   localparam int P_HOLD   = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          sample_valid = 1'b0;
   logic          evt_ready = 1'b0;
   logic [DW-1:0] filt_data = '0;
   logic [DW-1:0] threshold = 16'd100;
   logic          evt_valid;
   logic [DW-1:0] evt_amp;
   logic [TW-1:0] evt_ts;
   logic          busy;
   logic [7:0]    reject_cnt;
   logic [7:0]    pileup_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n_ts    = 0;

   // Reference model: event-level view built from queues of samples.
   int m_phase = P_IDLE;
   int m_ts    = 0;
   int m_ets   = 0;
   int m_amp   = 0;
   int m_rej   = 0;
   int m_pile  = 0;
   int pulse[$];
   bit hbelow[$];

   always #5 clk = ~clk;

   trap_peak_ctrl #(
      .SIZE_OUT_DATA(DW), .K(K), .L(L), .TS_W(TW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .sample_valid(sample_valid),
      .filt_data   (filt_data),
      .threshold   (threshold),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_amp     (evt_amp),
      .evt_ts      (evt_ts),
      .busy        (busy),
      .reject_cnt  (reject_cnt),
      .pileup_cnt  (pileup_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_ts = 0; m_ets = 0; m_amp = 0; m_rej = 0; m_pile = 0;
      pulse.delete();
      hbelow.delete();
   endtask

   task automatic model_step();
      bit above;
      int cur;
      int mx;
      above = filt_data > threshold;
      cur   = m_ts;
      if (sample_valid) m_ts = (m_ts + 1) % (1 << TW);
      if (!enable) begin
         m_phase = P_IDLE;
      end else if (m_phase == P_IDLE) begin
         m_phase = P_ARMED;
      end else if (m_phase == P_ARMED) begin
         if (sample_valid && above) begin
            m_ets = cur;
            pulse.delete();
            m_phase = P_PULSE;
         end
      end else if (m_phase == P_PULSE) begin
         if (sample_valid) begin
            if (pulse.size() < K && !above) begin
               if (m_rej < 255) m_rej++;
               m_phase = P_ARMED;
            end else begin
               pulse.push_back(int'(filt_data));
               if (pulse.size() == L) begin
                  mx = pulse[K];
                  for (int i = K + 1; i < L; i++) if (pulse[i] > mx) mx = pulse[i];
                  m_amp = mx;
                  m_phase = P_REPORT;
               end
            end
         end
      end else if (m_phase == P_REPORT) begin
         if (evt_ready) begin
            hbelow.delete();
            m_phase = P_HOLD;
         end
      end else begin
         if (sample_valid) begin
            if (above && hbelow.size() > 0 && hbelow[$]) begin
               if (m_pile < 255) m_pile++;
            end
            hbelow.push_back(!above);
            if (hbelow.size() >= K + L && !above) m_phase = P_ARMED;
         end
      end
   endtask

   task automatic compare();
      check("evt_valid", evt_valid, m_phase == P_REPORT);
      check("busy", busy, m_phase >= P_PULSE);
      check("reject_cnt", reject_cnt, m_rej);
      check("pileup_cnt", pileup_cnt, m_pile);
      if (m_phase == P_REPORT) begin
         check("evt_amp", evt_amp, m_amp);
         check("evt_ts", evt_ts, m_ets);
      end
   endtask

   task automatic drive(input bit v, input int d);
      sample_valid = v;
      filt_data    = DW'(d);
      model_step();
      if (v) n_ts++;
      @(negedge clk);
      compare();
   endtask

   task automatic run_pulse();
      int pk[8];
      pk = '{150, 200, 300, 400, 500, 520, 510, 505};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, pk[i]);
         if (i == 6) check("no_valid_before_8th", evt_valid, 1'b0);
      end
   endtask

   initial begin
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_evt_valid", evt_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_evt_amp", evt_amp, 0);
      check("rst_evt_ts", evt_ts, 0);
      check("rst_reject", reject_cnt, 0);
      check("rst_pileup", pileup_cnt, 0);
      reset = 1'b1;
      n_ts  = 0;

      // Trigger at ts=10 followed by the rise/flat sequence.
      repeat (10) drive(1'b1, 50);
      drive(1'b1, 120);
      run_pulse();
      check("pk_valid", evt_valid, 1);
      check("pk_amp", evt_amp, 520);
      check("pk_ts", evt_ts, 10);

      // Back-pressure then handshake.
      evt_ready = 1'b0;
      repeat (20) drive(1'b1, 50);
      check("bp_valid", evt_valid, 1);
      check("bp_amp", evt_amp, 520);
      check("bp_ts", evt_ts, 10);
      evt_ready = 1'b1;
      drive(1'b1, 50);
      evt_ready = 1'b0;
      check("hs_valid_low", evt_valid, 0);
      check("hs_holdoff_busy", busy, 1);

      // Holdoff with pile-up and extended holdoff.
      drive(1'b1, 50);
      drive(1'b1, 200);
      check("pileup_one", pileup_cnt, 1);
      repeat (10) drive(1'b1, 200);
      check("hold_end_high_busy", busy, 1);
      repeat (3) drive(1'b1, 200);
      check("hold_ext_busy", busy, 1);
      check("hold_ext_pileup", pileup_cnt, 1);
      drive(1'b1, 80);
      check("hold_exit_armed", busy, 0);

      // Short-pulse reject.
      drive(1'b1, 150);
      drive(1'b1, 160);
      drive(1'b1, 90);
      check("rej_busy", busy, 0);
      check("rej_count", reject_cnt, 1);
      check("rej_no_valid", evt_valid, 0);

      // Asynchronous reset during the flat top.
      drive(1'b1, 200);
      repeat (6) drive(1'b1, 300);
      check("flat_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_amp", evt_amp, 0);
      check("arst_reject", reject_cnt, 0);
      check("arst_pileup", pileup_cnt, 0);
      check("arst_valid", evt_valid, 0);
      @(negedge clk);
      model_reset();
      compare();
      reset = 1'b1;
      n_ts  = 0;
      repeat (3) drive(1'b1, 10);
      drive(1'b1, 200);
      run_pulse();
      check("post_rst_valid", evt_valid, 1);
      check("post_rst_amp", evt_amp, 520);
      check("post_rst_ts", evt_ts, 3);
      evt_ready = 1'b1;
      drive(1'b1, 10);
      evt_ready = 1'b0;

      // Trigger two counts before the timestamp wraps.
      for (int i = 0; i < 300 && n_ts != 254; i++) drive(1'b1, 10);
      drive(1'b1, 200);
      run_pulse();
      check("wrap_valid", evt_valid, 1);
      check("wrap_ts", evt_ts, 254);
      evt_ready = 1'b1;
      drive(1'b1, 10);
      evt_ready = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         enable    = ($urandom_range(0, 199) != 0);
         evt_ready = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 49) == 0) threshold = DW'($urandom_range(50, 300));
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
